apb_fifo_slave: RTL and testbench

// APB completer fronting a synchronous FIFO; it is the slave the APB UVC drives.

---
 rtl/apb_fifo_slave.sv | 278 +++++++++++++++++++++++++++
 tb/tb_apb_fifo_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_slave.sv
// apb_fifo_slave: APB completer in front of a synchronous FIFO.
// Writes to DATA (0x0) push a word, reads from DATA pop the head word.
// STAT (0x4) reports count/empty/full/ovf/udf, CTRL (0x8) flushes the FIFO
// and clears the sticky overflow/underflow flags, THR (0xC) holds the irq
// threshold.
// Ports:
//   system_clock, reset_n              clock and async active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata, pstrobe, pprot             APB request (pprot is ignored)
//   pready, prdata, pslverr            APB response, all registered
//   fifo_full, fifo_empty, irq         registered FIFO status
module apb_fifo_slave #(
  parameter int ADDR  = 32,
  parameter int DATA  = 32,
  parameter int DEPTH = 16
) (
  input  logic              system_clock,
  input  logic              reset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR-1:0]   paddr,
  input  logic [DATA-1:0]   pwdata,
  input  logic [DATA/8-1:0] pstrobe,
  input  logic [2:0]        pprot,
  output logic              pready,
  output logic [DATA-1:0]   prdata,
  output logic              pslverr,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // The APB setup phase is decoded while the FSM sits in IDLE, so pready
  // can be registered on the edge that ends it (zero wait states).
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RDW = 2'd1, ST_ACC = 2'd2} state_t;

  // Side effect remembered from the setup phase, applied when ACC ends.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_SET_OVF = 3'd3,
    OP_SET_UDF = 3'd4, OP_CTRL = 3'd5, OP_THR = 3'd6
  } op_t;

  state_t             state_r;
  op_t                op_r;
  op_t                op_s;
  logic               pready_r;
  logic               pslverr_r;
  logic [DATA-1:0]    prdata_r;
  logic [DATA-1:0]    mem [DEPTH];
  logic [PW-1:0]      wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0]      count_r, count_nxt_s;
  logic [CW-1:0]      thresh_r, thresh_nxt_s;
  logic               ovf_r, udf_r, ovf_nxt_s, udf_nxt_s;
  logic               full_r, empty_r, irq_r;
  logic               err_s, rdw_s, addr_bad_s, commit_s;
  logic [DATA-1:0]    rd_val_s;
  logic               unused_s;

  assign unused_s = ^{pprot, paddr[ADDR-1:4]};

  assign pready     = pready_r;
  assign pslverr    = pslverr_r;
  assign prdata     = prdata_r;
  assign fifo_full  = full_r;
  assign fifo_empty = empty_r;
  assign irq        = irq_r;

  // Setup-phase decode: operation, error and read value of the request.
  always_comb begin
    op_s       = OP_NONE;
    err_s      = 1'b0;
    rdw_s      = 1'b0;
    rd_val_s   = '0;
    addr_bad_s = (paddr[1:0] != 2'b00) || (paddr[3:0] > 4'hC);
    if (addr_bad_s) begin
      err_s = 1'b1;
    end else begin
      case (paddr[3:2])
        2'd0: begin
          if (pwrite) begin
            if (full_r) begin
              err_s = 1'b1;
              op_s  = OP_SET_OVF;
            end else if (pstrobe != {(DATA/8){1'b1}}) begin
              err_s = 1'b1;
            end else begin
              op_s = OP_PUSH;
            end
          end else begin
            if (empty_r) begin
              err_s = 1'b1;
              op_s  = OP_SET_UDF;
            end else begin
              op_s  = OP_POP;
              rdw_s = 1'b1;
            end
          end
        end
        2'd1: begin
          if (pwrite) begin
            err_s = 1'b1;
          end else begin
            rd_val_s[CW-1:0] = count_r;
            rd_val_s[16]     = empty_r;
            rd_val_s[17]     = full_r;
            rd_val_s[18]     = ovf_r;
            rd_val_s[19]     = udf_r;
          end
        end
        2'd2: begin
          if (pwrite) begin
            op_s = OP_CTRL;
          end else begin
            rd_val_s = '0;
          end
        end
        2'd3: begin
          if (pwrite) begin
            op_s = OP_THR;
          end else begin
            rd_val_s[CW-1:0] = thresh_r;
          end
        end
        default: begin
          err_s = 1'b1;
        end
      endcase
    end
  end

  // Next FIFO/control state; only changes on the edge that completes ACC.
  always_comb begin
    commit_s     = (state_r == ST_ACC) && psel && penable;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    ovf_nxt_s    = ovf_r;
    udf_nxt_s    = udf_r;
    thresh_nxt_s = thresh_r;
    if (commit_s) begin
      case (op_r)
        OP_PUSH: begin
          wr_ptr_nxt_s = wr_ptr_r + PW'(1);
          count_nxt_s  = count_r + CW'(1);
        end
        OP_POP: begin
          rd_ptr_nxt_s = rd_ptr_r + PW'(1);
          count_nxt_s  = count_r - CW'(1);
        end
        OP_SET_OVF: ovf_nxt_s = 1'b1;
        OP_SET_UDF: udf_nxt_s = 1'b1;
        OP_CTRL: begin
          if (pwdata[0]) begin
            count_nxt_s  = '0;
            wr_ptr_nxt_s = rd_ptr_r;
          end else begin
            count_nxt_s = count_r;
          end
          if (pwdata[1]) begin
            ovf_nxt_s = 1'b0;
          end else begin
            ovf_nxt_s = ovf_r;
          end
          if (pwdata[2]) begin
            udf_nxt_s = 1'b0;
          end else begin
            udf_nxt_s = udf_r;
          end
        end
        OP_THR: begin
          if (pwdata > DATA'(DEPTH)) begin
            thresh_nxt_s = CW'(DEPTH);
          end else begin
            thresh_nxt_s = pwdata[CW-1:0];
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO storage; not reset, flush only moves the write pointer.
  always_ff @(posedge system_clock) begin
    if (commit_s && (op_r == OP_PUSH)) begin
      mem[wr_ptr_r] <= pwdata;
    end
  end

  // FIFO pointers, count, sticky flags, threshold and registered status.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      thresh_r <= CW'(DEPTH / 2);
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      irq_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ovf_r    <= ovf_nxt_s;
      udf_r    <= udf_nxt_s;
      thresh_r <= thresh_nxt_s;
      full_r   <= (count_nxt_s == CW'(DEPTH));
      empty_r  <= (count_nxt_s == '0);
      irq_r    <= (thresh_nxt_s != '0) && (count_nxt_s >= thresh_nxt_s);
    end
  end

  // APB transfer FSM with registered pready/pslverr/prdata.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_NONE;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
          prdata_r  <= '0;
          if (psel && !penable) begin
            op_r <= op_s;
            if (rdw_s) begin
              // DATA read: one wait state while the head word is fetched.
              state_r <= ST_RDW;
            end else begin
              state_r   <= ST_ACC;
              pready_r  <= 1'b1;
              pslverr_r <= err_s;
              prdata_r  <= rd_val_s;
            end
          end
        end
        ST_RDW: begin
          if (!psel) begin
            // Master abandoned the transfer: nothing is popped.
            state_r <= ST_IDLE;
            op_r    <= OP_NONE;
          end else begin
            state_r  <= ST_ACC;
            pready_r <= 1'b1;
            prdata_r <= mem[rd_ptr_r];
          end
        end
        ST_ACC: begin
          state_r   <= ST_IDLE;
          op_r      <= OP_NONE;
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
          prdata_r  <= '0;
        end
        default: begin
          state_r   <= ST_IDLE;
          op_r      <= OP_NONE;
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
          prdata_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fifo_slave.sv
module tb_apb_fifo_slave;

  localparam int DEPTH = 16;

  logic        system_clock = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrobe;
  logic [2:0]  pprot;
  logic        pready, pslverr, fifo_full, fifo_empty, irq;

  apb_fifo_slave #(.ADDR(32), .DATA(32), .DEPTH(DEPTH)) dut (
    .system_clock(system_clock), .reset_n(reset_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrobe(pstrobe), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .irq(irq)
  );

  always #5 system_clock = ~system_clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic        chk_data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_q[$];
  logic        m_ovf, m_udf;
  int          m_thr;
  int          compared = 0;
  int          mismatched = 0;
  int          mon_waits = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_thr = DEPTH / 2;
  endtask

  // Reference behaviour of one transfer, straight from the register map.
  task automatic model_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            output exp_t e);
    int a;
    a = int'(addr[3:0]);
    e.rdata = 32'h0; e.err = 1'b0; e.waits = 0; e.chk_data = !wr;
    if ((a % 4) != 0 || a > 12) begin
      e.err = 1'b1;
      e.chk_data = 1'b0;
    end else if (a == 0) begin
      if (wr) begin
        if (model_q.size() == DEPTH) begin e.err = 1'b1; m_ovf = 1'b1; end
        else if (strb != 4'hF) e.err = 1'b1;
        else model_q.push_back(data);
      end else begin
        if (model_q.size() == 0) begin e.err = 1'b1; m_udf = 1'b1; end
        else begin e.rdata = model_q.pop_front(); e.waits = 1; end
      end
    end else if (a == 4) begin
      if (wr) e.err = 1'b1;
      else e.rdata = model_q.size() + ((model_q.size() == 0) ? 32'h1_0000 : 32'h0)
                   + ((model_q.size() == DEPTH) ? 32'h2_0000 : 32'h0)
                   + (m_ovf ? 32'h4_0000 : 32'h0) + (m_udf ? 32'h8_0000 : 32'h0);
    end else if (a == 8) begin
      if (wr) begin
        if (data[0]) model_q.delete();
        if (data[1]) m_ovf = 1'b0;
        if (data[2]) m_udf = 1'b0;
      end
    end else begin
      if (wr) m_thr = (data > DEPTH) ? DEPTH : int'(data);
      else e.rdata = m_thr;
    end
  endtask

  task automatic check_flags();
    cmp("fifo_full",  {31'h0, fifo_full},  {31'h0, model_q.size() == DEPTH});
    cmp("fifo_empty", {31'h0, fifo_empty}, {31'h0, model_q.size() == 0});
    cmp("irq",        {31'h0, irq},        {31'h0, (m_thr != 0) && (model_q.size() >= m_thr)});
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int   n;
    model_xfer(wr, addr, data, strb, e);
    exp_q.push_back(e);
    @(posedge system_clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrobe = strb; pprot = 3'($urandom_range(0, 7));
    @(posedge system_clock); #1;
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge system_clock);
      n++;
    end while (!pready && n < 8);
    if (!pready) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: pready still 0 after %0d cycles, required 1", n);
    end
    @(posedge system_clock); #1;
    psel = 1'b0; penable = 1'b0;
    check_flags();
  endtask

  // Monitor: pops the expected response whenever the DUT completes a transfer.
  always @(negedge system_clock) begin
    exp_t e;
    if (reset_n) begin
      if (psel && !penable) begin
        mon_waits = 0;
      end else if (psel && penable) begin
        if (!pready) begin
          mon_waits++;
        end else if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_completion: got a response, required none");
        end else begin
          e = exp_q.pop_front();
          cmp("pslverr", {31'h0, pslverr}, {31'h0, e.err});
          cmp("wait_states", mon_waits, e.waits);
          if (e.chk_data) cmp("prdata", prdata, e.rdata);
        end
      end
    end
  end

  initial begin
    logic [31:0] addr, data;
    logic [3:0]  strb;
    int          r;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    pwdata = 32'h0; pstrobe = 4'hF; pprot = 3'h0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge system_clock);
    @(negedge system_clock);
    reset_n = 1'b1;
    cmp("reset_pready", {31'h0, pready}, 32'h0);
    cmp("reset_pslverr", {31'h0, pslverr}, 32'h0);
    check_flags();

    // 1. STAT after reset
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF);
    // 2. fill, then overflow
    for (int i = 1; i <= 16; i++) apb_xfer(1'b1, 32'h0, 32'hA5A5_0000 + i, 4'hF);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF);
    apb_xfer(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF);
    // 3. drain, then underflow
    for (int i = 1; i <= 16; i++) apb_xfer(1'b0, 32'h0, 32'h0, 4'hF);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'hF);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF);
    apb_xfer(1'b1, 32'h8, 32'h6, 4'hF);
    // partial strobe, STAT write, misaligned and out-of-map accesses
    apb_xfer(1'b1, 32'h0, 32'h1234_5678, 4'h7);
    apb_xfer(1'b1, 32'h4, 32'h0, 4'hF);
    apb_xfer(1'b1, 32'h2, 32'h1, 4'hF);
    apb_xfer(1'b0, 32'hD, 32'h0, 4'hF);
    // 4. pointer wrap
    for (int i = 0; i < 10; i++) apb_xfer(1'b1, 32'h0, 32'hB000_0000 + i, 4'hF);
    for (int i = 0; i < 10; i++) apb_xfer(1'b0, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 12; i++) apb_xfer(1'b1, 32'h0, 32'hC000_0000 + i, 4'hF);
    for (int i = 0; i < 12; i++) apb_xfer(1'b0, 32'h0, 32'h0, 4'hF);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF);
    // 5. threshold and flush
    apb_xfer(1'b1, 32'hC, 32'h4, 4'hF);
    for (int i = 0; i < 4; i++) apb_xfer(1'b1, 32'h0, 32'hD000_0000 + i, 4'hF);
    apb_xfer(1'b1, 32'h8, 32'h1, 4'hF);
    apb_xfer(1'b1, 32'hC, 32'h0, 4'hF);
    apb_xfer(1'b1, 32'h0, 32'hD000_0100, 4'hF);
    apb_xfer(1'b1, 32'hC, 32'h99, 4'hF);
    apb_xfer(1'b0, 32'hC, 32'h0, 4'hF);

    // abort a DATA read during its wait state: nothing popped
    @(posedge system_clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    @(posedge system_clock); #1;
    penable = 1'b1;
    #2;
    psel = 1'b0; penable = 1'b0;
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'hF);

    // 6. reset during the read wait state
    apb_xfer(1'b1, 32'h0, 32'hE000_0001, 4'hF);
    apb_xfer(1'b1, 32'h0, 32'hE000_0002, 4'hF);
    @(posedge system_clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    @(posedge system_clock); #1;
    penable = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    cmp("reset_mid_pready", {31'h0, pready}, 32'h0);
    model_reset();
    check_flags();
    psel = 1'b0; penable = 1'b0;
    @(negedge system_clock);
    reset_n = 1'b1;
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF);
    apb_xfer(1'b0, 32'hC, 32'h0, 4'hF);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      data = $urandom;
      strb = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      addr = {28'($urandom), 4'h0};
      if (r < 40)      apb_xfer(1'b1, addr, data, strb);
      else if (r < 70) apb_xfer(1'b0, addr, data, strb);
      else if (r < 78) apb_xfer(1'b0, addr | 32'h4, data, strb);
      else if (r < 80) apb_xfer(1'b1, addr | 32'h4, data, strb);
      else if (r < 83) apb_xfer(1'b1, addr | 32'h8, 32'($urandom_range(0, 7)), strb);
      else if (r < 88) apb_xfer(1'b1, addr | 32'hC, 32'($urandom_range(0, 20)), strb);
      else if (r < 92) apb_xfer(1'b0, addr | 32'hC, data, strb);
      else if (r < 95) apb_xfer(1'b0, addr | 32'h8, data, strb);
      else             apb_xfer(1'($urandom_range(0, 1)), addr | 32'($urandom_range(13, 15)), data, strb);
    end

    repeat (2) @(posedge system_clock);
    cmp("pending_responses", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
